// File: rtl/prmcu_uart_pkg.sv
`default_nettype none
// ============================================================================
// Module      : prmcu_uart_pkg
// Description : Types, constants and helpers shared by the prmcu UART paths.
// Revision    : 1.0 - initial release
// ============================================================================
package prmcu_uart_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } uart_tx_state_t;

    localparam logic [3:0] UART_MIN_DATA_BITS = 4'd5;
    localparam logic [3:0] UART_MAX_DATA_BITS = 4'd9;

    function automatic logic [3:0] uart_clamp_data_bits(input logic [3:0] n_bits);
        if (n_bits < UART_MIN_DATA_BITS) begin
            return UART_MIN_DATA_BITS;
        end else if (n_bits > UART_MAX_DATA_BITS) begin
            return UART_MAX_DATA_BITS;
        end
        return n_bits;
    endfunction

    function automatic logic [1:0] uart_clamp_stop_bits(input logic [1:0] n_stop);
        return (n_stop == 2'd0) ? 2'd1 : n_stop;
    endfunction

    // Even parity over the first n_bits of dat; also used by the receiver.
    function automatic logic uart_parity(input logic [8:0] dat, input logic [3:0] n_bits);
        logic w_par;
        w_par = 1'b0;
        for (int i = 0; i < 9; i++) begin
            if (i < int'(n_bits)) begin
                w_par = w_par ^ dat[i];
            end
        end
        return w_par;
    endfunction

endpackage
`default_nettype wire

// File: rtl/prmcu_uart_baud_gen.sv
`default_nettype none
// ============================================================================
// Module      : prmcu_uart_baud_gen
// Description : Bit-period divider; bit_tick pulses on the last cycle of a bit.
// Revision    : 1.0 - initial release
// ============================================================================
module prmcu_uart_baud_gen
    import prmcu_uart_pkg::*;
#(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             enable,
    input  logic [CNT_W-1:0] divider,
    output logic             bit_tick
);

    localparam logic [CNT_W-1:0] c_one = {{(CNT_W-1){1'b0}}, 1'b1};

    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_last;
    logic             w_wrap;

    // A divider of 0 behaves as 1, so the last count is 0 either way.
    assign w_last   = (divider == '0) ? '0 : (divider - c_one);
    assign w_wrap   = (r_cnt == w_last);
    assign bit_tick = enable & w_wrap;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (clear) begin
            r_cnt <= '0;
        end else if (enable) begin
            r_cnt <= w_wrap ? '0 : (r_cnt + c_one);
        end
    end

endmodule
`default_nettype wire

// File: rtl/prmcu_uart_tx.sv
`default_nettype none
// ============================================================================
// Module      : prmcu_uart_tx
// Description : UART transmitter: start, 5-9 data bits LSB first, optional
//               even parity, 1-3 stop bits, valid/ready word input.
// Revision    : 1.0 - initial release
// ============================================================================
module prmcu_uart_tx
    import prmcu_uart_pkg::*;
#(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             uart_en,
    input  logic             tx_en,
    input  logic             n_parity_bits_i,
    input  logic [1:0]       n_stop_bits_i,
    input  logic [3:0]       n_data_bits_i,
    input  logic [CNT_W-1:0] internal_clk_divider_i,
    input  logic [8:0]       in_dat_i,
    input  logic             in_vld_i,
    output logic             in_rdy_o,
    output logic             tx_o,
    output logic             tx_busy_o
);

    uart_tx_state_t   r_state;
    uart_tx_state_t   w_state_next;
    logic [3:0]       r_idx;
    logic [3:0]       w_idx_next;
    logic             r_tx;
    logic             w_tx_next;
    logic             r_rdy;

    // Frame parameters captured at accept; inputs are ignored mid-frame.
    logic [8:0]       r_dat;
    logic [3:0]       r_n_data;
    logic             r_par_en;
    logic [1:0]       r_n_stop;
    logic [CNT_W-1:0] r_div;

    logic             w_accept;
    logic             w_tick;
    logic             w_clear;
    logic [3:0]       w_last_data;
    logic [3:0]       w_last_stop;
    logic [8:0]       w_dat_shift;

    assign in_rdy_o    = r_rdy & uart_en & tx_en;
    assign tx_busy_o   = (r_state != ST_IDLE);
    assign tx_o        = r_tx;
    assign w_accept    = in_vld_i & in_rdy_o;
    assign w_clear     = w_accept | ~uart_en;
    assign w_last_data = r_n_data - 4'd1;
    assign w_last_stop = {2'b00, r_n_stop} - 4'd1;
    assign w_dat_shift = r_dat >> w_idx_next;

    prmcu_uart_baud_gen #(
        .CNT_W (CNT_W)
    ) u_baud_gen (
        .clk      (clk),
        .rst      (rst),
        .clear    (w_clear),
        .enable   (tx_busy_o),
        .divider  (r_div),
        .bit_tick (w_tick)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= ST_IDLE;
            r_idx    <= '0;
            r_tx     <= 1'b1;
            r_rdy    <= 1'b0;
            r_dat    <= '0;
            r_n_data <= '0;
            r_par_en <= 1'b0;
            r_n_stop <= '0;
            r_div    <= '0;
        end else begin
            r_state <= w_state_next;
            r_idx   <= w_idx_next;
            r_tx    <= w_tx_next;
            r_rdy   <= (w_state_next == ST_IDLE);
            if (w_accept) begin
                r_dat    <= in_dat_i;
                r_n_data <= uart_clamp_data_bits(n_data_bits_i);
                r_par_en <= n_parity_bits_i;
                r_n_stop <= uart_clamp_stop_bits(n_stop_bits_i);
                r_div    <= internal_clk_divider_i;
            end
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_idx_next   = r_idx;
        if (!uart_en) begin
            w_state_next = ST_IDLE;
            w_idx_next   = '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        w_state_next = ST_START;
                        w_idx_next   = '0;
                    end
                end
                ST_START: begin
                    if (w_tick) begin
                        w_state_next = ST_DATA;
                        w_idx_next   = '0;
                    end
                end
                ST_DATA: begin
                    if (w_tick) begin
                        if (r_idx == w_last_data) begin
                            w_state_next = r_par_en ? ST_PARITY : ST_STOP;
                            w_idx_next   = '0;
                        end else begin
                            w_idx_next = r_idx + 4'd1;
                        end
                    end
                end
                ST_PARITY: begin
                    if (w_tick) begin
                        w_state_next = ST_STOP;
                        w_idx_next   = '0;
                    end
                end
                ST_STOP: begin
                    if (w_tick) begin
                        if (r_idx == w_last_stop) begin
                            w_state_next = ST_IDLE;
                            w_idx_next   = '0;
                        end else begin
                            w_idx_next = r_idx + 4'd1;
                        end
                    end
                end
                default: begin
                    w_state_next = ST_IDLE;
                    w_idx_next   = '0;
                end
            endcase
        end
    end

    // Line level is decoded from the next state so tx_o comes straight from a flop.
    always_comb begin
        w_tx_next = 1'b1;
        case (w_state_next)
            ST_START:  w_tx_next = 1'b0;
            ST_DATA:   w_tx_next = w_dat_shift[0];
            ST_PARITY: w_tx_next = uart_parity(r_dat, r_n_data);
            default:   w_tx_next = 1'b1;
        endcase
    end

endmodule
`default_nettype wire

// File: tb/tb_prmcu_uart_tx.sv
`default_nettype none
// ============================================================================
// Module      : tb_prmcu_uart_tx
// Description : Self-checking bench for prmcu_uart_tx against a per-cycle
//               line model built from whole frames.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_prmcu_uart_tx;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       uart_en;
    logic       tx_en;
    logic       n_parity_bits_i;
    logic [1:0] n_stop_bits_i;
    logic [3:0] n_data_bits_i;
    logic [7:0] internal_clk_divider_i;
    logic [8:0] in_dat_i;
    logic       in_vld_i;
    logic       in_rdy_o;
    logic       tx_o;
    logic       tx_busy_o;

    int n_tests = 0;
    int n_fail  = 0;

    prmcu_uart_tx #(
        .CNT_W (8)
    ) dut (
        .clk                    (clk),
        .rst                    (rst),
        .uart_en                (uart_en),
        .tx_en                  (tx_en),
        .n_parity_bits_i        (n_parity_bits_i),
        .n_stop_bits_i          (n_stop_bits_i),
        .n_data_bits_i          (n_data_bits_i),
        .internal_clk_divider_i (internal_clk_divider_i),
        .in_dat_i               (in_dat_i),
        .in_vld_i               (in_vld_i),
        .in_rdy_o               (in_rdy_o),
        .tx_o                   (tx_o),
        .tx_busy_o              (tx_busy_o)
    );

    initial forever #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
        end
    endtask

    // Model: queue of expected line levels, one entry per clk cycle of the frame.
    bit m_line[$];
    bit m_rdy_reg = 1'b0;
    bit m_was_idle;
    int m_accepts = 0;

    function automatic void m_push_frame(input logic [8:0] dat, input logic [3:0] nd_raw,
                                         input logic par, input logic [1:0] ns_raw,
                                         input logic [7:0] d_raw);
        int nd;
        int ns;
        int d;
        bit p;
        bit bits[$];
        nd = (int'(nd_raw) < 5) ? 5 : ((int'(nd_raw) > 9) ? 9 : int'(nd_raw));
        ns = (ns_raw == 2'd0) ? 1 : int'(ns_raw);
        d  = (d_raw == 8'd0) ? 1 : int'(d_raw);
        p  = 1'b0;
        bits.push_back(1'b0);
        for (int i = 0; i < nd; i++) begin
            bits.push_back(dat[i]);
            p ^= dat[i];
        end
        if (par) bits.push_back(p);
        for (int i = 0; i < ns; i++) bits.push_back(1'b1);
        foreach (bits[i]) begin
            for (int j = 0; j < d; j++) m_line.push_back(bits[i]);
        end
    endfunction

    initial begin
        forever begin
            @(posedge clk or posedge rst);
            if (rst) begin
                m_line.delete();
                m_rdy_reg = 1'b0;
            end else if (!uart_en) begin
                m_line.delete();
                m_rdy_reg = 1'b1;
            end else begin
                m_was_idle = (m_line.size() == 0);
                if (!m_was_idle) begin
                    void'(m_line.pop_front());
                end else if (m_rdy_reg && tx_en && in_vld_i) begin
                    m_push_frame(in_dat_i, n_data_bits_i, n_parity_bits_i,
                                 n_stop_bits_i, internal_clk_divider_i);
                    m_accepts++;
                end
                m_rdy_reg = (m_line.size() == 0);
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            chk("cyc_tx", 32'(tx_o), 32'((m_line.size() != 0) ? m_line[0] : 1'b1));
            chk("cyc_busy", 32'(tx_busy_o), 32'(m_line.size() != 0));
            chk("cyc_rdy", 32'(in_rdy_o), 32'(m_rdy_reg & uart_en & tx_en));
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic cfg(input logic [7:0] d, input logic [3:0] nd, input logic par,
                       input logic [1:0] ns);
        internal_clk_divider_i = d;
        n_data_bits_i          = nd;
        n_parity_bits_i        = par;
        n_stop_bits_i          = ns;
    endtask

    // Called at edge+1; returns at edge+1 just after the accepting edge.
    task automatic send(input logic [8:0] dat);
        bit ok;
        ok       = 1'b0;
        in_dat_i = dat;
        in_vld_i = 1'b1;
        for (int t = 0; t < 2000 && !ok; t++) begin
            #1;
            ok = in_rdy_o;
            @(posedge clk);
            #1;
        end
        in_vld_i = 1'b0;
        if (!ok) chk("send_timeout", 32'd0, 32'd1);
    endtask

    bit exp_a5[8]   = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
    bit exp_1fb[10] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
    int start_acc;

    initial begin
        uart_en  = 1'b1;
        tx_en    = 1'b1;
        in_vld_i = 1'b0;
        in_dat_i = '0;
        cfg(8'd87, 4'd8, 1'b0, 2'd1);
        rst = 1'b1;
        tick(3);
        chk("reset_tx", 32'(tx_o), 32'd1);
        chk("reset_busy", 32'(tx_busy_o), 32'd0);
        chk("reset_rdy", 32'(in_rdy_o), 32'd0);
        rst = 1'b0;
        tick(1);
        chk("rdy_after_reset", 32'(in_rdy_o), 32'd1);

        // 8N1, D=87, 0xA5
        send(9'h0A5);
        tick(43);
        chk("a5_start", 32'(tx_o), 32'd0);
        for (int i = 0; i < 8; i++) begin
            tick(87);
            chk("a5_data", 32'(tx_o), 32'(exp_a5[i]));
        end
        tick(87);
        chk("a5_stop", 32'(tx_o), 32'd1);
        tick(43);
        chk("a5_rdy_869", 32'(in_rdy_o), 32'd0);
        chk("a5_busy_869", 32'(tx_busy_o), 32'd1);
        tick(1);
        chk("a5_rdy_870", 32'(in_rdy_o), 32'd1);
        chk("a5_busy_870", 32'(tx_busy_o), 32'd0);

        // D=4, 6 data bits, parity, 2 stop, 0x1FB
        cfg(8'd4, 4'd6, 1'b1, 2'd2);
        send(9'h1FB);
        tick(2);
        for (int j = 0; j < 10; j++) begin
            chk("fb_bit", 32'(tx_o), 32'(exp_1fb[j]));
            if (j < 9) tick(4);
        end
        tick(1);
        chk("fb_busy_39", 32'(tx_busy_o), 32'd1);
        tick(1);
        chk("fb_rdy_40", 32'(in_rdy_o), 32'd1);

        // D=0, 2 data bits, 0 stop -> D=1, 5 data, 1 stop
        cfg(8'd0, 4'd2, 1'b0, 2'd0);
        send(9'h015);
        tick(4);
        chk("min_bit3", 32'(tx_o), 32'd0);
        tick(1);
        chk("min_bit4", 32'(tx_o), 32'd1);
        tick(1);
        chk("min_busy_6", 32'(tx_busy_o), 32'd1);
        tick(1);
        chk("min_busy_7", 32'(tx_busy_o), 32'd0);

        // 15 data bits -> 9
        cfg(8'd0, 4'd15, 1'b0, 2'd1);
        send(9'h100);
        tick(8);
        chk("max_bit7", 32'(tx_o), 32'd0);
        tick(1);
        chk("max_bit8", 32'(tx_o), 32'd1);
        tick(1);
        chk("max_busy_10", 32'(tx_busy_o), 32'd1);
        tick(1);
        chk("max_busy_11", 32'(tx_busy_o), 32'd0);

        // uart_en dropped in data bit 3
        cfg(8'd4, 4'd8, 1'b0, 2'd1);
        send(9'h000);
        tick(17);
        chk("abort_bit3", 32'(tx_o), 32'd0);
        uart_en = 1'b0;
        tick(1);
        chk("abort_tx", 32'(tx_o), 32'd1);
        chk("abort_busy", 32'(tx_busy_o), 32'd0);
        uart_en = 1'b1;
        send(9'h03C);
        tick(14);
        chk("3c_bit2", 32'(tx_o), 32'd1);
        tick(16);
        chk("3c_bit6", 32'(tx_o), 32'd0);
        tick(10);
        chk("3c_rdy_40", 32'(in_rdy_o), 32'd1);

        // tx_en dropped mid-DATA
        send(9'h05A);
        tick(10);
        tx_en    = 1'b0;
        in_vld_i = 1'b1;
        tick(31);
        chk("txen_busy_41", 32'(tx_busy_o), 32'd0);
        chk("txen_rdy_41", 32'(in_rdy_o), 32'd0);
        tick(5);
        chk("txen_no_accept", 32'(tx_busy_o), 32'd0);
        in_vld_i = 1'b0;
        tx_en    = 1'b1;
        #1;
        chk("txen_rdy_back", 32'(in_rdy_o), 32'd1);
        tick(1);

        // async reset mid-STOP
        send(9'h000);
        tick(37);
        chk("rst_pre_busy", 32'(tx_busy_o), 32'd1);
        #2;
        rst = 1'b1;
        #1;
        chk("rst_async_tx", 32'(tx_o), 32'd1);
        chk("rst_async_busy", 32'(tx_busy_o), 32'd0);
        chk("rst_async_rdy", 32'(in_rdy_o), 32'd0);
        tick(1);
        rst = 1'b0;
        tick(1);
        chk("rst_rdy_back", 32'(in_rdy_o), 32'd1);

        // 100 words streamed with valid held high and config churning every cycle
        start_acc = m_accepts;
        in_vld_i  = 1'b1;
        for (int c = 0; c < 20000 && (m_accepts - start_acc) < 100; c++) begin
            in_dat_i               = 9'($urandom);
            n_data_bits_i          = 4'($urandom_range(0, 15));
            n_stop_bits_i          = 2'($urandom_range(0, 3));
            n_parity_bits_i        = 1'($urandom_range(0, 1));
            internal_clk_divider_i = 8'($urandom_range(0, 3));
            tick(1);
        end
        in_vld_i = 1'b0;
        chk("stream_words", 32'(m_accepts - start_acc), 32'd100);
        for (int c = 0; c < 200 && m_line.size() != 0; c++) tick(1);
        tick(2);
        chk("stream_idle_busy", 32'(tx_busy_o), 32'd0);
        chk("stream_idle_tx", 32'(tx_o), 32'd1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
